// File: rtl/decimator_ctrl.sv
// Decimation sequencer: keeps every Nth accepted sample after sync alignment and
// presents it on a registered valid/ready output with sticky overflow/config-error flags.
module decimator_ctrl #(
   parameter int DATA_WIDTH    = 8,
   parameter int RATIO_WIDTH   = 16,
   parameter int DEFAULT_RATIO = 2
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [RATIO_WIDTH-1:0] cfg_ratio,
   input  logic                   cfg_load,
   input  logic                   sync_i,
   input  logic [DATA_WIDTH-1:0]  data_in,
   input  logic                   data_in_valid,
   input  logic                   data_ready,
   output logic [DATA_WIDTH-1:0]  data_out,
   output logic                   data_valid,
   output logic                   busy,
   output logic                   overflow,
   output logic                   cfg_err,
   output logic [1:0]             state_dbg
);

   // Output handshake: a sample moves downstream on any cycle where
   // data_valid & data_ready; data_out is held stable while data_valid & !data_ready.

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      RUN   = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam logic [RATIO_WIDTH-1:0] ONE         = RATIO_WIDTH'(1);
   localparam logic [RATIO_WIDTH-1:0] RESET_RATIO =
      (DEFAULT_RATIO < 2) ? ONE : RATIO_WIDTH'(DEFAULT_RATIO);

   state_t                 state;
   logic [RATIO_WIDTH-1:0] ratio;
   logic [RATIO_WIDTH-1:0] phase;
   logic [RATIO_WIDTH-1:0] ratio_m1;
   logic [RATIO_WIDTH-1:0] cur_phase;
   logic [RATIO_WIDTH-1:0] phase_inc;
   logic                   arm_go;
   logic                   realign;
   logic                   accept;
   logic                   hit;
   logic                   xfer;

   // Ratio is never below 1, so ratio-1 cannot wrap and phase never exceeds it.
   always_comb begin
      ratio_m1  = ratio - ONE;
      arm_go    = (state == ARM) && en && sync_i;
      realign   = arm_go || ((state == RUN) && sync_i);
      accept    = (state == RUN) || arm_go;
      cur_phase = realign ? '0 : phase;
      phase_inc = (cur_phase == ratio_m1) ? '0 : cur_phase + ONE;
      hit       = accept && data_in_valid && (cur_phase == '0);
      xfer      = data_valid && data_ready;
   end

   assign state_dbg = state;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= IDLE;
         ratio      <= RESET_RATIO;
         phase      <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
         busy       <= 1'b0;
         overflow   <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         if (cfg_load) begin
            if (state == IDLE)
               ratio <= (cfg_ratio <= ONE) ? ONE : cfg_ratio;
            else
               cfg_err <= 1'b1;
         end

         if (accept) begin
            if (data_in_valid)
               phase <= phase_inc;
            else if (realign)
               phase <= '0;
         end

         // A hit may reuse the slot in the same cycle it is being drained.
         if (hit && (!data_valid || data_ready)) begin
            data_out   <= data_in;
            data_valid <= 1'b1;
         end else if (hit) begin
            overflow <= 1'b1;
         end else if (xfer) begin
            data_valid <= 1'b0;
         end

         case (state)
            IDLE: if (en) begin
               state <= ARM;
               busy  <= 1'b1;
            end
            ARM: if (!en) begin
               state <= IDLE;
               busy  <= 1'b0;
            end else if (sync_i) begin
               state <= RUN;
            end
            RUN: if (!en) state <= DRAIN;
            DRAIN: if (!data_valid || data_ready) begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_decimator_ctrl.sv
// Directed bench for decimator_ctrl: per-cycle vector table plus a reset-mid-run sequence.
module tb_decimator_ctrl;

   localparam int DW = 8;
   localparam int RW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic [RW-1:0] cfg_ratio;
   logic          cfg_load;
   logic          sync_i;
   logic [DW-1:0] data_in;
   logic          data_in_valid;
   logic          data_ready;
   logic [DW-1:0] data_out;
   logic          data_valid;
   logic          busy;
   logic          overflow;
   logic          cfg_err;
   logic [1:0]    state_dbg;

   int checks = 0;
   int errors = 0;

   decimator_ctrl #(.DATA_WIDTH(DW), .RATIO_WIDTH(RW), .DEFAULT_RATIO(2)) dut (
      .clk(clk), .rst(rst), .en(en), .cfg_ratio(cfg_ratio), .cfg_load(cfg_load),
      .sync_i(sync_i), .data_in(data_in), .data_in_valid(data_in_valid),
      .data_ready(data_ready), .data_out(data_out), .data_valid(data_valid),
      .busy(busy), .overflow(overflow), .cfg_err(cfg_err), .state_dbg(state_dbg)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          en;
      logic          load;
      logic [RW-1:0] ratio;
      logic          sync;
      logic          vld;
      logic [DW-1:0] din;
      logic          rdy;
      logic [DW-1:0] e_dout;
      logic          e_dv;
      logic          e_busy;
      logic          e_ovf;
      logic          e_err;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input logic en_v, input logic load_v, input int ratio_v,
                               input logic sync_v, input logic vld_v, input int din_v,
                               input logic rdy_v, input int e_dout, input logic e_dv,
                               input logic e_busy, input logic e_ovf, input logic e_err);
      vec_t v;
      v.en = en_v; v.load = load_v; v.ratio = RW'(ratio_v); v.sync = sync_v;
      v.vld = vld_v; v.din = DW'(din_v); v.rdy = rdy_v;
      v.e_dout = DW'(e_dout); v.e_dv = e_dv; v.e_busy = e_busy;
      v.e_ovf = e_ovf; v.e_err = e_err;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic drive(input logic en_v, input logic load_v, input int ratio_v,
                        input logic sync_v, input logic vld_v, input int din_v,
                        input logic rdy_v);
      en = en_v; cfg_load = load_v; cfg_ratio = RW'(ratio_v); sync_i = sync_v;
      data_in_valid = vld_v; data_in = DW'(din_v); data_ready = rdy_v;
      @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string tag, input int e_dout, input logic e_dv,
                             input logic e_busy, input logic e_ovf, input logic e_err);
      check({tag, ".data_out"}, int'(data_out), e_dout);
      check({tag, ".data_valid"}, int'(data_valid), int'(e_dv));
      check({tag, ".busy"}, int'(busy), int'(e_busy));
      check({tag, ".overflow"}, int'(overflow), int'(e_ovf));
      check({tag, ".cfg_err"}, int'(cfg_err), int'(e_err));
   endtask

   initial begin
      rst = 1'b0;
      en = 1'b0; cfg_load = 1'b0; cfg_ratio = '0; sync_i = 1'b0;
      data_in = '0; data_in_valid = 1'b0; data_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_outs("reset", 0, 0, 0, 0, 0);
      check("reset.state", int'(state_dbg), 0);
      rst = 1'b1;

      // en load ratio sync vld din rdy | dout dv busy ovf err
      // ratio 3, sync on sample 10 -> 10,13,16,19
      add(0, 1, 3, 0, 0,  0, 0,   0, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0,  0, 0,   0, 0, 1, 0, 0);
      add(1, 0, 0, 0, 1,  5, 1,   0, 0, 1, 0, 0);
      add(1, 0, 0, 1, 1, 10, 1,  10, 1, 1, 0, 0);
      add(1, 0, 0, 0, 1, 11, 1,  10, 0, 1, 0, 0);
      add(1, 0, 0, 0, 1, 12, 1,  10, 0, 1, 0, 0);
      add(1, 0, 0, 0, 1, 13, 1,  13, 1, 1, 0, 0);
      add(1, 0, 0, 0, 0,  0, 1,  13, 0, 1, 0, 0);
      add(1, 0, 0, 0, 1, 14, 1,  13, 0, 1, 0, 0);
      add(1, 0, 0, 0, 1, 15, 1,  13, 0, 1, 0, 0);
      add(1, 0, 0, 0, 1, 16, 1,  16, 1, 1, 0, 0);
      add(1, 0, 0, 0, 1, 17, 1,  16, 0, 1, 0, 0);
      add(1, 0, 0, 0, 1, 18, 1,  16, 0, 1, 0, 0);
      add(1, 0, 0, 0, 1, 19, 1,  19, 1, 1, 0, 0);
      add(0, 0, 0, 0, 0,  0, 1,  19, 0, 1, 0, 0);
      add(0, 0, 0, 0, 0,  0, 1,  19, 0, 0, 0, 0);
      // ratio 0 stored as 1: pass-through; cfg_load while running -> cfg_err
      add(0, 1, 0, 0, 0,  0, 0,  19, 0, 0, 0, 0);
      add(1, 0, 0, 0, 0,  0, 1,  19, 0, 1, 0, 0);
      add(1, 0, 0, 1, 1, 30, 1,  30, 1, 1, 0, 0);
      add(1, 0, 0, 0, 1, 31, 1,  31, 1, 1, 0, 0);
      add(1, 0, 0, 0, 1, 32, 1,  32, 1, 1, 0, 0);
      add(1, 1, 5, 0, 1, 33, 1,  33, 1, 1, 0, 1);
      add(1, 0, 0, 0, 1, 34, 1,  34, 1, 1, 0, 1);
      add(0, 0, 0, 0, 0,  0, 1,  34, 0, 1, 0, 1);
      add(0, 0, 0, 0, 0,  0, 1,  34, 0, 0, 0, 1);
      // ratio 2 with ready low over five hits -> first value held, overflow
      add(0, 1, 2, 0, 0,  0, 0,  34, 0, 0, 0, 1);
      add(1, 0, 0, 0, 0,  0, 0,  34, 0, 1, 0, 1);
      add(1, 0, 0, 1, 1, 40, 0,  40, 1, 1, 0, 1);
      add(1, 0, 0, 0, 1, 41, 0,  40, 1, 1, 0, 1);
      add(1, 0, 0, 0, 1, 42, 0,  40, 1, 1, 1, 1);
      add(1, 0, 0, 0, 1, 43, 0,  40, 1, 1, 1, 1);
      add(1, 0, 0, 0, 1, 44, 0,  40, 1, 1, 1, 1);
      add(1, 0, 0, 0, 1, 45, 0,  40, 1, 1, 1, 1);
      add(1, 0, 0, 0, 1, 46, 0,  40, 1, 1, 1, 1);
      add(1, 0, 0, 0, 1, 47, 0,  40, 1, 1, 1, 1);
      add(1, 0, 0, 0, 1, 48, 0,  40, 1, 1, 1, 1);
      add(1, 0, 0, 0, 0,  0, 1,  40, 0, 1, 1, 1);
      add(1, 0, 0, 0, 1, 49, 1,  40, 0, 1, 1, 1);
      add(1, 0, 0, 0, 1, 50, 1,  50, 1, 1, 1, 1);
      add(1, 0, 0, 0, 1, 51, 1,  50, 0, 1, 1, 1);
      add(0, 0, 0, 0, 0,  0, 1,  50, 0, 1, 1, 1);
      add(0, 0, 0, 0, 0,  0, 1,  50, 0, 0, 1, 1);
      // ratio 4, resync on a phase-2 sample of value 50 -> 50 then 54
      add(0, 1, 4, 0, 0,  0, 0,  50, 0, 0, 1, 1);
      add(1, 0, 0, 0, 0,  0, 1,  50, 0, 1, 1, 1);
      add(1, 0, 0, 1, 1, 44, 1,  44, 1, 1, 1, 1);
      add(1, 0, 0, 0, 1, 45, 1,  44, 0, 1, 1, 1);
      add(1, 0, 0, 0, 1, 46, 1,  44, 0, 1, 1, 1);
      add(1, 0, 0, 0, 1, 47, 1,  44, 0, 1, 1, 1);
      add(1, 0, 0, 0, 1, 48, 1,  48, 1, 1, 1, 1);
      add(1, 0, 0, 0, 1, 49, 1,  48, 0, 1, 1, 1);
      add(1, 0, 0, 1, 1, 50, 1,  50, 1, 1, 1, 1);
      add(1, 0, 0, 0, 1, 51, 1,  50, 0, 1, 1, 1);
      add(1, 0, 0, 0, 1, 52, 1,  50, 0, 1, 1, 1);
      add(1, 0, 0, 0, 1, 53, 1,  50, 0, 1, 1, 1);
      add(1, 0, 0, 0, 1, 54, 1,  54, 1, 1, 1, 1);
      // stop with a held output: drain waits for ready, ignores new input
      add(0, 0, 0, 0, 0,  0, 0,  54, 1, 1, 1, 1);
      add(0, 0, 0, 0, 1, 99, 0,  54, 1, 1, 1, 1);
      add(0, 0, 0, 0, 0,  0, 1,  54, 0, 0, 1, 1);

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].en, vecs[i].load, int'(vecs[i].ratio), vecs[i].sync,
               vecs[i].vld, int'(vecs[i].din), vecs[i].rdy);
         check_outs($sformatf("row%0d", i), int'(vecs[i].e_dout), vecs[i].e_dv,
                    vecs[i].e_busy, vecs[i].e_ovf, vecs[i].e_err);
      end
      check("drain_end.state", int'(state_dbg), 0);

      // reset while running with a held sample, then confirm ratio is back to 2
      drive(1, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 1, 1, 77, 0);
      check_outs("pre_rst", 77, 1, 1, 1, 1);
      rst = 1'b0;
      drive(1, 0, 0, 0, 1, 88, 0);
      check_outs("mid_rst", 0, 0, 0, 0, 0);
      check("mid_rst.state", int'(state_dbg), 0);
      rst = 1'b1;
      drive(1, 0, 0, 0, 0, 0, 1);
      check("post_rst.state", int'(state_dbg), 1);
      drive(1, 0, 0, 1, 1, 1, 1);
      check_outs("post_rst.s1", 1, 1, 1, 0, 0);
      drive(1, 0, 0, 0, 1, 2, 1);
      check_outs("post_rst.s2", 1, 0, 1, 0, 0);
      drive(1, 0, 0, 0, 1, 3, 1);
      check_outs("post_rst.s3", 3, 1, 1, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/decimator_ctrl.md
Name: decimator_ctrl

Overview:
- Sequencing controller for the shared decimator datapath.
- Takes a sample stream with a valid qualifier and keeps every Nth accepted sample; N is a runtime-programmable ratio.
- Aligns decimation phase to an external sync pulse, runs a start/stop state machine, and presents results on a registered valid/ready output with overflow detection.
- Sits between the ADC/sample source and downstream DSP blocks; the same counter/strobe scheme serves as the decimation scheduler.

Parameters:
- DATA_WIDTH, 8: sample width in bits.
- RATIO_WIDTH, 16: width of the decimation ratio register.
- DEFAULT_RATIO, 2: ratio loaded at reset.

Ports:
- clk  in  1  single system clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
- en  in  1  run request: 1 = start/keep running, 0 = stop.
- cfg_ratio  in  RATIO_WIDTH  new decimation ratio.
- cfg_load  in  1  one-cycle strobe to load cfg_ratio.
- sync_i  in  1  phase-alignment pulse.
- data_in  in  DATA_WIDTH  input sample.
- data_in_valid  in  1  data_in qualifier.
- data_ready  in  1  downstream accepts data_out this cycle.
- data_out  out  DATA_WIDTH  decimated sample (registered).
- data_valid  out  1  data_out holds an unconsumed sample.
- busy  out  1  state != IDLE.
- overflow  out  1  sticky: a decimated sample was dropped.
- cfg_err  out  1  sticky: cfg_load arrived outside IDLE.

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, ratio=DEFAULT_RATIO, phase=0, data_out=0, data_valid=0, busy=0, overflow=0, cfg_err=0. Reset mid-operation discards any held output immediately.
- Ratio rules:
  - cfg_load in IDLE latches cfg_ratio at the next edge; values 0 and 1 are stored as 1 (pass-through).
  - cfg_load in any other state is ignored and sets cfg_err.
  - Sticky flags clear only on reset.
- FSM:
  - IDLE: en=1 -> ARM.
  - ARM: waits for sync_i=1 -> RUN, with phase forced to 0 so the sample coincident with sync (if data_in_valid) is phase 0. en=0 -> IDLE.
  - RUN: en=0 -> DRAIN.
  - DRAIN: no new inputs accepted; -> IDLE once data_valid=0 (same cycle if already 0).
- Phase counter (RUN only):
  - Advances on each data_in_valid cycle, 0..ratio-1, then wraps to 0.
  - sync_i=1 in RUN realigns phase to 0, treating the current valid sample as phase 0; the counter then continues from 1.
  - data_in_valid=0 holds phase.
  - Inputs in IDLE/ARM/DRAIN are ignored and phase does not move, except the ARM sync sample.
- Capture:
  - A valid sample at phase 0 is a "hit".
  - Latency: data_out/data_valid update on the edge that samples the hit (visible the cycle after the input is presented).
- Output handshake:
  - Transfer occurs when data_valid & data_ready.
  - Hit with data_valid=0: load data_out, set data_valid.
  - Hit with transfer in the same cycle: load the new sample, data_valid stays 1, no overflow.
  - Hit with data_valid=1 and data_ready=0: keep the old data_out, drop the new sample, set overflow.
  - Transfer without a hit: clear data_valid; data_out holds its value.
  - data_out is stable while data_valid=1 and data_ready=0.
- Width: phase counter is RATIO_WIDTH bits; compare against ratio-1 with no overflow past the max ratio (2^RATIO_WIDTH - 1).

Test Plan:
- Reset, ratio=3 load, en=1, sync at sample 10, data_in=counter 10,11,12..., data_ready=1 -> data_out 10,13,16,19; data_valid pulses every 3rd valid cycle, 1-cycle latency.
- cfg_ratio=0 in IDLE, run with ready=1 -> every valid sample passes (ratio 1); cfg_load during RUN -> cfg_err=1, ratio unchanged.
- Ratio 2, data_ready=0 held for 5 hits -> data_out stays first captured value, overflow=1; ready=1 -> one transfer, then resumes.
- Ratio 4 running, sync_i pulsed on a phase-2 sample of value 50 -> 50 output, next output 54.
- en=0 with data_valid=1, ready=0 -> DRAIN, busy=1; ready=1 -> transfer, IDLE next cycle, busy=0.
- rst=0 asserted mid-RUN with data_valid=1 -> next edge: all outputs 0, state IDLE, ratio back to 2.
